// File: rtl/mouse_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mouse_pkg
//  Description : Shared types and constants for the PS/2 mouse master:
//                sequencer and stream state encodings, host command bytes,
//                expected mouse responses, receiver error-code bit positions.
//  Revision    : 1.0  initial release
// ============================================================================
package mouse_pkg;

   // Initialisation sequencer states; STREAMING hands control to the assembler
   typedef enum logic [3:0] {
      INIT_WAIT   = 4'd0,
      SEND_FF     = 4'd1,
      WAIT_TX_FF  = 4'd2,
      WAIT_RX_FA1 = 4'd3,
      WAIT_RX_AA  = 4'd4,
      WAIT_RX_ID  = 4'd5,
      SEND_F4     = 4'd6,
      WAIT_TX_F4  = 4'd7,
      WAIT_RX_FA2 = 4'd8,
      STREAMING   = 4'd9
   } init_state_t;

   // Packet assembler states
   typedef enum logic [1:0] {
      STREAM_B1 = 2'd0,
      STREAM_B2 = 2'd1,
      STREAM_B3 = 2'd2,
      PUBLISH   = 2'd3
   } stream_state_t;

   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;
   localparam logic [7:0] RSP_ACK    = 8'hFA;
   localparam logic [7:0] RSP_BAT_OK = 8'hAA;
   localparam logic [7:0] RSP_ID     = 8'h00;

   localparam int ERR_PARITY_BIT = 0;
   localparam int ERR_STOP_BIT   = 1;

   // A byte counts only when it is flagged ready and carries no error
   function automatic logic byte_good(input logic ready, input logic [1:0] err);
      return ready && !err[ERR_PARITY_BIT] && !err[ERR_STOP_BIT];
   endfunction

endpackage
`default_nettype wire

// File: rtl/mouse_master_sm_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mouse_master_sm_if
//  Description : Bundle of the transmitter handshake, receiver handshake and
//                published packet signals of the PS/2 mouse master.
//                master = controller side, slave = PHY / consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface mouse_master_sm_if;
   logic       SEND_BYTE;
   logic [7:0] BYTE_TO_SEND;
   logic       BYTE_SENT;
   logic       READ_ENABLE;
   logic [7:0] BYTE_READ;
   logic [1:0] BYTE_ERROR_CODE;
   logic       BYTE_READY;
   logic [7:0] MOUSE_STATUS;
   logic [7:0] MOUSE_DX;
   logic [7:0] MOUSE_DY;
   logic       SEND_INTERRUPT;
   logic       INIT_DONE;

   modport master (
      output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
      output MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT, INIT_DONE,
      input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
   );

   modport slave (
      input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
      input  MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT, INIT_DONE,
      output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
   );
endinterface
`default_nettype wire

// File: rtl/mouse_packet_assembler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mouse_packet_assembler
//  Description : Collects 3-byte PS/2 stream packets (status, DX, DY) into
//                shadow registers and publishes them with a one-cycle
//                interrupt. Held in STREAM_B1 while enable is low.
//  Revision    : 1.0  initial release
// ============================================================================
module mouse_packet_assembler
   import mouse_pkg::*;
(
   input  wire logic       CLK,
   input  wire logic       RESET,
   input  wire logic       enable,
   input  wire logic       byte_ready,
   input  wire logic [1:0] byte_error_code,
   input  wire logic [7:0] byte_read,
   output logic      [7:0] mouse_status,
   output logic      [7:0] mouse_dx,
   output logic      [7:0] mouse_dy,
   output logic            send_interrupt,
   output logic            advance
);

   stream_state_t r_state;
   stream_state_t w_next_state;
   logic          w_good;
   logic          w_latch_status;
   logic          w_latch_dx;
   logic          w_latch_dy;
   logic          w_publish;
   logic [7:0]    r_sh_status;
   logic [7:0]    r_sh_dx;
   logic [7:0]    r_sh_dy;

   assign w_good = byte_good(byte_ready, byte_error_code);

   // State register; parked on the first packet byte while disabled
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)        r_state <= STREAM_B1;
      else if (!enable) r_state <= STREAM_B1;
      else              r_state <= w_next_state;
   end

   // Next state: byte 1 must have bit3 set (sync bit), errors restart the packet
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         STREAM_B1: if (w_good && byte_read[3]) w_next_state = STREAM_B2;
         STREAM_B2: if (byte_ready) w_next_state = w_good ? STREAM_B3 : STREAM_B1;
         STREAM_B3: if (byte_ready) w_next_state = w_good ? PUBLISH : STREAM_B1;
         PUBLISH:   w_next_state = STREAM_B1;
         default:   w_next_state = STREAM_B1;
      endcase
   end

   // Output decode: shadow load strobes, publish strobe, progress indication
   always_comb begin
      w_latch_status = enable && (r_state == STREAM_B1) && w_good && byte_read[3];
      w_latch_dx     = enable && (r_state == STREAM_B2) && w_good;
      w_latch_dy     = enable && (r_state == STREAM_B3) && w_good;
      w_publish      = enable && (r_state == PUBLISH);
      advance        = enable && (w_next_state != r_state);
   end

   // Shadow and published registers; interrupt rises with the new outputs
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_sh_status    <= 8'h00;
         r_sh_dx        <= 8'h00;
         r_sh_dy        <= 8'h00;
         mouse_status   <= 8'h00;
         mouse_dx       <= 8'h00;
         mouse_dy       <= 8'h00;
         send_interrupt <= 1'b0;
      end else begin
         if (w_latch_status) r_sh_status <= byte_read;
         if (w_latch_dx)     r_sh_dx     <= byte_read;
         if (w_latch_dy)     r_sh_dy     <= byte_read;
         if (w_publish) begin
            mouse_status <= r_sh_status;
            mouse_dx     <= r_sh_dx;
            mouse_dy     <= r_sh_dy;
         end
         send_interrupt <= w_publish;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mouse_master_sm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mouse_master_sm
//  Description : PS/2 mouse master. Power-on wait, Reset (0xFF) with
//                FA/AA/00 reply check, Enable Data Reporting (0xF4) with FA
//                check, then stream packets via mouse_packet_assembler.
//                Optional macro MOUSE_WATCHDOG_EN: restart initialisation
//                when a wait state sees no progress for WATCHDOG_CYCLES.
//  Revision    : 1.0  initial release
// ============================================================================
module mouse_master_sm
   import mouse_pkg::*;
#(
   parameter int unsigned INIT_WAIT_CYCLES = 5000000,
   parameter int unsigned WATCHDOG_CYCLES  = 100000000
)(
   input  wire logic         CLK,
   input  wire logic         RESET,
   mouse_master_sm_if.master bus
);

`ifdef MOUSE_WATCHDOG_EN
   localparam bit c_watchdog_on = 1'b1;
`else
   localparam bit c_watchdog_on = 1'b0;
`endif
   localparam logic [31:0] c_init_last     = 32'(INIT_WAIT_CYCLES - 1);
   localparam logic [31:0] c_watchdog_last = 32'(WATCHDOG_CYCLES - 1);

   init_state_t r_state;
   init_state_t w_next_state;
   logic [31:0] r_counter;
   logic        w_good;
   logic        w_wd_expired;
   logic        w_stream_advance;
   logic        w_init_done;

   assign w_good = byte_good(bus.BYTE_READY, bus.BYTE_ERROR_CODE);
   // Constant-false when the watchdog is compiled out, so the compare folds away
   assign w_wd_expired = c_watchdog_on && (r_counter == c_watchdog_last);

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= INIT_WAIT;
      else       r_state <= w_next_state;
   end

   // Cycle counter: restarts on any sequencer or assembler state change
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                                           r_counter <= 32'd0;
      else if ((w_next_state != r_state) || w_stream_advance) r_counter <= 32'd0;
      else                                                 r_counter <= r_counter + 32'd1;
   end

   // Next state: any wrong or corrupted reply during init forces a full retry
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         INIT_WAIT:   if (r_counter == c_init_last) w_next_state = SEND_FF;
         SEND_FF:     w_next_state = WAIT_TX_FF;
         WAIT_TX_FF:  if (bus.BYTE_SENT) w_next_state = WAIT_RX_FA1;
                      else if (w_wd_expired) w_next_state = INIT_WAIT;
         WAIT_RX_FA1: if (bus.BYTE_READY)
                         w_next_state = (w_good && bus.BYTE_READ == RSP_ACK) ? WAIT_RX_AA : INIT_WAIT;
                      else if (w_wd_expired) w_next_state = INIT_WAIT;
         WAIT_RX_AA:  if (bus.BYTE_READY)
                         w_next_state = (w_good && bus.BYTE_READ == RSP_BAT_OK) ? WAIT_RX_ID : INIT_WAIT;
                      else if (w_wd_expired) w_next_state = INIT_WAIT;
         WAIT_RX_ID:  if (bus.BYTE_READY)
                         w_next_state = (w_good && bus.BYTE_READ == RSP_ID) ? SEND_F4 : INIT_WAIT;
                      else if (w_wd_expired) w_next_state = INIT_WAIT;
         SEND_F4:     w_next_state = WAIT_TX_F4;
         WAIT_TX_F4:  if (bus.BYTE_SENT) w_next_state = WAIT_RX_FA2;
                      else if (w_wd_expired) w_next_state = INIT_WAIT;
         WAIT_RX_FA2: if (bus.BYTE_READY)
                         w_next_state = (w_good && bus.BYTE_READ == RSP_ACK) ? STREAMING : INIT_WAIT;
                      else if (w_wd_expired) w_next_state = INIT_WAIT;
         STREAMING:   if (w_wd_expired && !w_stream_advance) w_next_state = INIT_WAIT;
         default:     w_next_state = INIT_WAIT;
      endcase
   end

   // Output decode: command request, receiver enable, init-done level
   always_comb begin
      bus.SEND_BYTE    = 1'b0;
      bus.BYTE_TO_SEND = 8'h00;
      bus.READ_ENABLE  = 1'b0;
      w_init_done      = 1'b0;
      case (r_state)
         SEND_FF:     begin bus.SEND_BYTE = 1'b1; bus.BYTE_TO_SEND = CMD_RESET;  end
         SEND_F4:     begin bus.SEND_BYTE = 1'b1; bus.BYTE_TO_SEND = CMD_ENABLE; end
         WAIT_RX_FA1,
         WAIT_RX_AA,
         WAIT_RX_ID,
         WAIT_RX_FA2: bus.READ_ENABLE = 1'b1;
         STREAMING:   begin bus.READ_ENABLE = 1'b1; w_init_done = 1'b1; end
         default:     ;
      endcase
      bus.INIT_DONE = w_init_done;
   end

   mouse_packet_assembler u_assembler (
      .CLK             (CLK),
      .RESET           (RESET),
      .enable          (w_init_done),
      .byte_ready      (bus.BYTE_READY),
      .byte_error_code (bus.BYTE_ERROR_CODE),
      .byte_read       (bus.BYTE_READ),
      .mouse_status    (bus.MOUSE_STATUS),
      .mouse_dx        (bus.MOUSE_DX),
      .mouse_dy        (bus.MOUSE_DY),
      .send_interrupt  (bus.SEND_INTERRUPT),
      .advance         (w_stream_advance)
   );

endmodule
`default_nettype wire
